// File: rtl/display_mode_sequencer.sv
// Display-mode sequencer: two synchronised, debounced push buttons step a
// one-hot hex/binary/base-ten select, or blank it, with a change pulse.
module display_mode_sequencer #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_next,
   input  logic       btn_off,
   output logic       s0,
   output logic       s1,
   output logic       s2,
   output logic [1:0] mode,
   output logic       changed
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_OFF = 2'b00,
      ST_HEX = 2'b01,
      ST_BIN = 2'b10,
      ST_DEC = 2'b11
   } state_t;

   // Index 0 is NEXT, index 1 is OFF.
   logic [1:0] btn_raw;
   logic [1:0] press;

   assign btn_raw = {btn_off, btn_next};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic             sync1_reg;
         logic             sync2_reg;
         logic             stable_reg;
         logic             press_reg;
         logic [CNT_W-1:0] cnt_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               sync1_reg  <= 1'b0;
               sync2_reg  <= 1'b0;
               stable_reg <= 1'b0;
               press_reg  <= 1'b0;
               cnt_reg    <= '0;
            end else begin
               sync1_reg <= btn_raw[gi];
               sync2_reg <= sync1_reg;
               press_reg <= 1'b0;
               // Any cycle that agrees with the accepted level restarts the count.
               if (sync2_reg == stable_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CNT_MAX) begin
                  stable_reg <= sync2_reg;
                  cnt_reg    <= '0;
                  press_reg  <= sync2_reg;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
         end

         assign press[gi] = press_reg;
      end
   endgenerate

   state_t     state_reg;
   state_t     state_next;
   state_t     prev_state_reg;
   logic [2:0] sel_reg;
   logic [2:0] sel_next;
   logic       changed_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_OFF;
         prev_state_reg <= ST_OFF;
         sel_reg        <= 3'b000;
         changed_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         prev_state_reg <= state_reg;
         sel_reg        <= sel_next;
         changed_reg    <= (state_reg != prev_state_reg);
      end
   end

   // OFF has priority over NEXT when both pulses land together.
   always_comb begin
      state_next = state_reg;
      if (press[1]) begin
         state_next = ST_OFF;
      end else if (press[0]) begin
         case (state_reg)
            ST_OFF:  state_next = ST_HEX;
            ST_HEX:  state_next = ST_BIN;
            ST_BIN:  state_next = ST_DEC;
            ST_DEC:  state_next = ST_HEX;
            default: state_next = ST_HEX;
         endcase
      end
   end

   // Selects are loaded alongside the state so they track it with no decode glitches.
   always_comb begin
      sel_next = 3'b000;
      case (state_next)
         ST_HEX:  sel_next = 3'b001;
         ST_BIN:  sel_next = 3'b010;
         ST_DEC:  sel_next = 3'b100;
         default: sel_next = 3'b000;
      endcase
   end

   assign s0      = sel_reg[0];
   assign s1      = sel_reg[1];
   assign s2      = sel_reg[2];
   assign mode    = state_reg;
   assign changed = changed_reg;

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Bench for display_mode_sequencer: directed button scenarios, a per-cycle
// behavioural model comparison, and literal step/latency checks.
module tb_display_mode_sequencer;

   localparam int DB = 4;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       btn_next = 1'b0;
   logic       btn_off  = 1'b0;
   logic       s0;
   logic       s1;
   logic       s2;
   logic [1:0] mode;
   logic       changed;

   display_mode_sequencer #(
      .DEBOUNCE_CYCLES(DB),
      .CNT_W(20)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_next(btn_next),
      .btn_off(btn_off),
      .s0(s0),
      .s1(s1),
      .s2(s2),
      .mode(mode),
      .changed(changed)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Inputs as the DUT saw them at the most recent rising edge.
   logic rst_s  = 1'b1;
   logic next_s = 1'b0;
   logic off_s  = 1'b0;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      rst_s  <= rst;
      next_s <= btn_next;
      off_s  <= btn_off;
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int sel_of(input int m);
      return (m == 0) ? 0 : (1 << (m - 1));
   endfunction

   // Model: button level accepted once the last DB synchronised samples all
   // disagree with it; mode steps one edge after a press; changed one edge later.
   logic [1:0]    m_s1 = '0;
   logic [1:0]    m_s2 = '0;
   logic [1:0]    m_stable = '0;
   logic [1:0]    m_press = '0;
   logic [DB-1:0] m_hist [2];
   logic [1:0]    m_raw;
   logic [1:0]    m_old_press;
   int            m_mode = 0;
   int            m_old_mode = 0;
   bit            m_flag = 1'b0;
   bit            m_changed = 1'b0;
   int            n_chg = 0;
   int            chg_edge = -1;
   int            last_mode = 0;

   initial begin
      m_hist[0] = '0;
      m_hist[1] = '0;
      forever begin
         @(negedge clk);
         if (rst_s) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_press = '0;
            m_hist[0] = '0; m_hist[1] = '0;
            m_mode = 0; m_flag = 1'b0; m_changed = 1'b0;
         end else begin
            m_raw       = {off_s, next_s};
            m_old_press = m_press;
            for (int b = 0; b < 2; b++) begin
               m_hist[b] = {m_hist[b][DB-2:0], m_s2[b]};
               if (m_hist[b] == {DB{~m_stable[b]}}) begin
                  m_stable[b] = ~m_stable[b];
                  m_press[b]  = m_stable[b];
               end else begin
                  m_press[b] = 1'b0;
               end
            end
            m_s2 = m_s1;
            m_s1 = m_raw;
            m_old_mode = m_mode;
            if (m_old_press[1])      m_mode = 0;
            else if (m_old_press[0]) m_mode = (m_mode == 3) ? 1 : m_mode + 1;
            m_changed = m_flag;
            m_flag    = (m_mode != m_old_mode);
         end
         check("cyc_sel", int'({s2, s1, s0}), sel_of(m_mode));
         check("cyc_mode", int'(mode), m_mode);
         check("cyc_changed", int'(changed), int'(m_changed));
         if (changed) n_chg++;
         if (int'(mode) != last_mode) begin
            chg_edge  = cyc;
            last_mode = int'(mode);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   int rise;
   int exp_mode [4] = '{1, 2, 3, 1};
   int exp_sel  [4] = '{1, 2, 4, 1};
   bit pat      [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      // Reset and idle
      tick(2);
      check("rst_mode", int'(mode), 0);
      check("rst_sel", int'({s2, s1, s0}), 0);
      check("rst_changed", int'(changed), 0);
      rst = 1'b0;
      tick(10);
      check("idle_mode", int'(mode), 0);
      check("idle_sel", int'({s2, s1, s0}), 0);
      $display("[TB] reset/idle: mode=%0d sel=%03b", mode, {s2, s1, s0});

      // Four clean NEXT presses
      for (int i = 0; i < 4; i++) begin
         n_chg    = 0;
         btn_next = 1'b1;
         rise     = cyc + 1;
         tick(8);
         btn_next = 1'b0;
         tick(8);
         check("step_mode", int'(mode), exp_mode[i]);
         check("step_sel", int'({s2, s1, s0}), exp_sel[i]);
         check("step_latency", chg_edge - rise, 6);
         check("step_pulses", n_chg, 1);
         $display("[TB] next press %0d: mode=%0d sel=%03b latency=%0d pulses=%0d",
                  i, mode, {s2, s1, s0}, chg_edge - rise, n_chg);
      end

      // Bounce shorter than the debounce window
      n_chg = 0;
      for (int i = 0; i < 7; i++) begin
         btn_next = pat[i];
         tick(1);
      end
      btn_next = 1'b0;
      tick(12);
      check("bounce_mode", int'(mode), 1);
      check("bounce_pulses", n_chg, 0);
      $display("[TB] bounce: mode=%0d pulses=%0d", mode, n_chg);

      // Step to BIN, then NEXT and OFF together
      btn_next = 1'b1;
      tick(8);
      btn_next = 1'b0;
      tick(8);
      check("pre_simul_mode", int'(mode), 2);
      n_chg    = 0;
      btn_next = 1'b1;
      btn_off  = 1'b1;
      rise     = cyc + 1;
      tick(8);
      btn_next = 1'b0;
      btn_off  = 1'b0;
      tick(8);
      check("simul_mode", int'(mode), 0);
      check("simul_sel", int'({s2, s1, s0}), 0);
      check("simul_latency", chg_edge - rise, 6);
      check("simul_pulses", n_chg, 1);
      $display("[TB] next+off: mode=%0d sel=%03b pulses=%0d", mode, {s2, s1, s0}, n_chg);

      // Long hold from OFF
      n_chg    = 0;
      btn_next = 1'b1;
      rise     = cyc + 1;
      tick(40);
      check("hold_mode", int'(mode), 1);
      check("hold_pulses", n_chg, 1);
      check("hold_latency", chg_edge - rise, 6);
      btn_next = 1'b0;
      tick(10);
      check("hold_release_mode", int'(mode), 1);
      $display("[TB] hold 40: mode=%0d pulses=%0d", mode, n_chg);

      // Reset in the middle of a debounce with the button held
      btn_next = 1'b1;
      tick(3);
      rst = 1'b1;
      tick(1);
      check("midrst_mode", int'(mode), 0);
      check("midrst_sel", int'({s2, s1, s0}), 0);
      rst  = 1'b0;
      rise = cyc + 1;
      tick(12);
      check("midrst_latency", chg_edge - rise, 6);
      check("midrst_final_mode", int'(mode), 1);
      btn_next = 1'b0;
      tick(10);
      $display("[TB] reset mid-debounce: mode=%0d latency=%0d", mode, chg_edge - rise);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
